// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add WIDTH x WIDTH multiplier retiring one multiplier bit per clock.
// Signed operation (magnitude capture + final negate) is built only when SEQ_MULT_SIGNED_EN is defined.
module seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   opA,
    input  logic [WIDTH-1:0]   opB,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] res
);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    sum;
    logic [PW-1:0]    product;
    logic [WIDTH-1:0] a_cap;
    logic [WIDTH-1:0] b_cap;
    logic             last;

`ifdef SEQ_MULT_SIGNED_EN
    logic neg;
    logic neg_cap;

    // The most negative value maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [PW-1:0] negate(input logic [PW-1:0] p);
        return ~p + PW'(1);
    endfunction

    assign a_cap   = is_signed ? magnitude(opA) : opA;
    assign b_cap   = is_signed ? magnitude(opB) : opB;
    assign neg_cap = is_signed & (opA[WIDTH-1] ^ opB[WIDTH-1]);
    assign product = neg ? negate(sum) : sum;
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign a_cap            = opA;
    assign b_cap            = opB;
    assign product          = sum;
`endif

    assign sum  = acc + (mplier[0] ? mcand : '0);
    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Capture in IDLE, one shift-add step per RUN cycle, product held untouched through DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            res    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt    <= '0;
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, a_cap};
                        mplier <= b_cap;
`ifdef SEQ_MULT_SIGNED_EN
                        neg    <= neg_cap;
`endif
                    end
                end
                RUN: begin
                    acc    <= sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        res <= product;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: 32-bit instance for function/handshake/reset, 8-bit instance for parametric checks.
module tb_seq_multiplier;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] res;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  opA8;
    logic [7:0]  opB8;
    logic        is_signed8;
    logic        out_valid8;
    logic        out_ready8;
    logic [15:0] res8;

    int passed = 0;
    int total  = 0;

    seq_multiplier #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opA(opA), .opB(opB), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .res(res)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .opA(opA8), .opB(opB8), .is_signed(is_signed8), .out_valid(out_valid8),
        .out_ready(out_ready8), .res(res8)
    );

    always #5 clk = ~clk;

    // Drives one op from IDLE, scrambles operands after capture, returns product and latency, then accepts it.
    task automatic run_op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                            output logic [63:0] r, output int lat);
        opA = a; opB = b; is_signed = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; opA = $urandom; opB = $urandom; is_signed = ~s;
        lat = 0;
        while (lat < 100 && out_valid !== 1'b1) begin
            @(posedge clk); #1;
            lat++;
        end
        r = res;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                           output logic [15:0] r, output int lat);
        opA8 = a; opB8 = b; is_signed8 = s; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0; opA8 = 8'h5A; opB8 = 8'hA5; is_signed8 = ~s;
        lat = 0;
        while (lat < 100 && out_valid8 !== 1'b1) begin
            @(posedge clk); #1;
            lat++;
        end
        r = res8;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; opA = '0; opB = '0; is_signed = 1'b0; out_ready = 1'b0;
        in_valid8 = 1'b0; opA8 = '0; opB8 = '0; is_signed8 = 1'b0; out_ready8 = 1'b0;
        #3;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
        total++; if (res !== 64'd0) $display("FAIL reset_res: got %h expected 0", res); else passed++;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [63:0] r;
        int lat;
        run_op32(32'd5, 32'd10, 1'b0, r, lat);
        total++; if (lat !== 32) $display("FAIL basic_latency: got %0d expected 32", lat); else passed++;
        total++; if (r !== 64'd50) $display("FAIL basic_5x10: got %h expected %h", r, 64'd50); else passed++;
    endtask

    task automatic test_corners();
        logic [63:0] r;
        int lat;
        run_op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, lat);
        total++; if (r !== 64'hFFFFFFFE00000001) $display("FAIL max_x_max: got %h expected %h", r, 64'hFFFFFFFE00000001); else passed++;
        total++; if (lat !== 32) $display("FAIL max_latency: got %0d expected 32", lat); else passed++;
        run_op32(32'h0, 32'h12345678, 1'b0, r, lat);
        total++; if (r !== 64'd0) $display("FAIL zero_x_op: got %h expected 0", r); else passed++;
        total++; if (lat !== 32) $display("FAIL zero_latency: got %0d expected 32", lat); else passed++;
    endtask

    task automatic test_signed();
        logic [63:0] r;
        logic [63:0] e;
        int lat;
        run_op32(32'hFFFFFFFD, 32'd7, 1'b1, r, lat);
`ifdef SEQ_MULT_SIGNED_EN
        e = 64'hFFFFFFFFFFFFFFEB;
`else
        e = 64'h00000006FFFFFFEB;
`endif
        total++; if (r !== e) $display("FAIL signed_m3x7: got %h expected %h", r, e); else passed++;
        run_op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, r, lat);
`ifdef SEQ_MULT_SIGNED_EN
        e = 64'h0000000000000001;
`else
        e = 64'hFFFFFFFE00000001;
`endif
        total++; if (r !== e) $display("FAIL signed_m1xm1: got %h expected %h", r, e); else passed++;
        run_op32(32'h80000000, 32'h80000000, 1'b1, r, lat);
        e = 64'h4000000000000000;
        total++; if (r !== e) $display("FAIL signed_minxmin: got %h expected %h", r, e); else passed++;
        total++; if (lat !== 32) $display("FAIL signed_latency: got %0d expected 32", lat); else passed++;
    endtask

    task automatic test_backpressure();
        int lat;
        opA = 32'd3; opB = 32'd4; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        opA = 32'd2; opB = 32'd9;
        lat = 0;
        while (lat < 100 && out_valid !== 1'b1) begin
            @(posedge clk); #1;
            lat++;
        end
        total++; if (res !== 64'd12) $display("FAIL bp_first_res: got %h expected %h", res, 64'd12); else passed++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, out_valid); else passed++;
            total++; if (in_ready !== 1'b0) $display("FAIL bp_hold_ready[%0d]: got %b expected 0", i, in_ready); else passed++;
            total++; if (res !== 64'd12) $display("FAIL bp_hold_res[%0d]: got %h expected %h", i, res, 64'd12); else passed++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b expected 0", out_valid); else passed++;
        // out_ready stays high through the next op; it must not cut RUN short
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 100 && out_valid !== 1'b1) begin
            @(posedge clk); #1;
            lat++;
        end
        total++; if (lat !== 32) $display("FAIL bp_next_latency: got %0d expected 32", lat); else passed++;
        total++; if (res !== 64'd18) $display("FAIL bp_next_res: got %h expected %h", res, 64'd18); else passed++;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) $display("FAIL bp_early_ready_take: got %b expected 0", out_valid); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [63:0] r;
        int lat;
        opA = 32'd9; opB = 32'd9; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL run_reset_valid: got %b expected 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL run_reset_ready: got %b expected 1", in_ready); else passed++;
        total++; if (res !== 64'd0) $display("FAIL run_reset_res: got %h expected 0", res); else passed++;
        @(posedge clk); #1 reset = 1'b0;
        run_op32(32'd6, 32'd7, 1'b0, r, lat);
        total++; if (r !== 64'd42) $display("FAIL after_reset_res: got %h expected %h", r, 64'd42); else passed++;
        total++; if (lat !== 32) $display("FAIL after_reset_latency: got %0d expected 32", lat); else passed++;

        opA = 32'd2; opB = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 100 && out_valid !== 1'b1) begin
            @(posedge clk); #1;
            lat++;
        end
        total++; if (res !== 64'd6) $display("FAIL done_before_reset_res: got %h expected %h", res, 64'd6); else passed++;
        reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL done_reset_valid: got %b expected 0", out_valid); else passed++;
        total++; if (res !== 64'd0) $display("FAIL done_reset_res: got %h expected 0", res); else passed++;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_width8();
        logic [15:0] r;
        logic [15:0] e;
        int lat;
        run_op8(8'hFF, 8'hFF, 1'b0, r, lat);
        total++; if (r !== 16'hFE01) $display("FAIL w8_ff_x_ff: got %h expected %h", r, 16'hFE01); else passed++;
        total++; if (lat !== 8) $display("FAIL w8_latency: got %0d expected 8", lat); else passed++;
        run_op8(8'h80, 8'h80, 1'b1, r, lat);
        total++; if (r !== 16'h4000) $display("FAIL w8_min_x_min: got %h expected %h", r, 16'h4000); else passed++;
        run_op8(8'hFF, 8'hFF, 1'b1, r, lat);
`ifdef SEQ_MULT_SIGNED_EN
        e = 16'h0001;
`else
        e = 16'hFE01;
`endif
        total++; if (r !== e) $display("FAIL w8_signed_m1xm1: got %h expected %h", r, e); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_signed();
        test_backpressure();
        test_reset_abort();
        test_width8();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
